// File: rtl/pixel_pkg.sv
// pixel_pkg: types and constants shared by the pixel frame store.
//   ram_state_t  - single-port RAM time-slot state (clear sweep, display read, brush write)
//   COLOR_*      - 3-bit palette codes used by the brush and colour mapper
//   ADDR_W       - SPRAM word address width (16K words)
//   pixel_addr() - packs {y, x} into a RAM address for a given canvas geometry
package pixel_pkg;

   localparam int unsigned ADDR_W  = 14;
   localparam int unsigned RAM_DW  = 16;
   localparam int unsigned COORD_W = 10;

   typedef enum logic [1:0] {
      RAM_CLEAR = 2'd0,
      RAM_READ  = 2'd1,
      RAM_WRITE = 2'd2
   } ram_state_t;

   localparam logic [2:0] COLOR_BLACK   = 3'b000;
   localparam logic [2:0] COLOR_BLUE    = 3'b001;
   localparam logic [2:0] COLOR_GREEN   = 3'b010;
   localparam logic [2:0] COLOR_CYAN    = 3'b011;
   localparam logic [2:0] COLOR_RED     = 3'b100;
   localparam logic [2:0] COLOR_MAGENTA = 3'b101;
   localparam logic [2:0] COLOR_YELLOW  = 3'b110;
   localparam logic [2:0] COLOR_WHITE   = 3'b111;

   // Keeps the low xw bits of x and the low yw bits of y; y lands above x.
   function automatic logic [ADDR_W-1:0] pixel_addr(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y,
                                                    input int unsigned xw,
                                                    input int unsigned yw);
      logic [ADDR_W-1:0] xm;
      logic [ADDR_W-1:0] ym;
      xm = ADDR_W'(x) & ((ADDR_W'(1) << xw) - ADDR_W'(1));
      ym = ADDR_W'(y) & ((ADDR_W'(1) << yw) - ADDR_W'(1));
      return (ym << xw) | xm;
   endfunction

endpackage

// File: rtl/pixel_spram.sv
// pixel_spram: 16K x 16 single-port RAM with SP256K pin behaviour (registered read,
// nibble write mask, chip select and power controls). Stands in for the SP256K hard block.
//   clk                     - clock
//   addr, din, we, maskwe   - address, write data, write enable, per-nibble write mask
//   cs, stdby, sleep,
//   pwroff_n                - the array only operates when selected and fully powered
//   dout                    - read data, valid the cycle after a read
module pixel_spram import pixel_pkg::*; (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   input  logic [RAM_DW-1:0] din,
   input  logic [3:0]        maskwe,
   input  logic              we,
   input  logic              cs,
   input  logic              stdby,
   input  logic              sleep,
   input  logic              pwroff_n,
   output logic [RAM_DW-1:0] dout
);

   localparam int unsigned WORDS = 1 << ADDR_W;

   logic [RAM_DW-1:0] mem_q [WORDS];
   logic [RAM_DW-1:0] dout_q;
   logic              active;

   assign active = cs && !stdby && !sleep && pwroff_n;

   always_ff @(posedge clk) begin
      if (active && we) begin
         for (int n = 0; n < 4; n++) begin
            if (maskwe[n]) mem_q[addr][n*4 +: 4] <= din[n*4 +: 4];
         end
      end
   end

   // Output holds its last read value during writes and idle cycles.
   always_ff @(posedge clk) begin
      if (active && !we) dout_q <= mem_q[addr];
   end

   assign dout = dout_q;

endmodule

// File: rtl/pixel_write_fifo.sv
// pixel_write_fifo: small synchronous FIFO buffering brush writes ahead of the RAM write slot.
//   clk, reset      - clock, synchronous active-low reset
//   flush           - empties the FIFO; a push in the same cycle is discarded
//   push/push_data  - enqueue one entry ({addr, color} at the top level)
//   pop/pop_data    - dequeue; pop_data shows the head entry combinationally
//   empty, count    - current occupancy
//   count_next      - occupancy after this cycle's push/pop/flush
module pixel_write_fifo #(
   parameter int unsigned WIDTH = 17,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] count_next
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push;
   logic             do_pop;
   logic             full;

   assign full  = (cnt_q == CNT_W'(DEPTH));
   assign empty = (cnt_q == '0);

   // Full/empty guards make an ill-timed request harmless instead of corrupting state.
   assign do_push = push && !flush && !full;
   assign do_pop  = pop && !flush && !empty;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         // DEPTH is a power of two, so the pointers wrap naturally.
         if (do_push) wr_d = wr_q + 1'b1;
         if (do_pop)  rd_d = rd_q + 1'b1;
         cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= push_data;
   end

   assign pop_data   = mem_q[rd_q];
   assign count      = cnt_q;
   assign count_next = cnt_d;

endmodule

// File: rtl/pixel_frame_store.sv
// pixel_frame_store: single-port framebuffer holding one colour code per canvas pixel.
// Display reads and brush writes share the RAM in alternating READ/WRITE slots; brush
// writes wait in a small FIFO. After reset or clear_req the array is swept to CLEAR_COLOR.
//   clk, reset         - clock, synchronous active-low reset
//   clear_req          - one-cycle pulse, (re)starts the clear sweep
//   wr_valid/wr_ready  - brush write handshake; wx, wy, newColor carry the write
//   rx, ry             - display coordinate, sampled in each READ slot
//   colorCode          - pixel colour, 2 cycles after the READ slot that sampled rx/ry
//   busy               - clear sweep in progress
module pixel_frame_store import pixel_pkg::*; #(
   parameter int unsigned        CANVAS_W      = 128,
   parameter int unsigned        CANVAS_H      = 128,
   parameter int unsigned        COLOR_W       = 3,
   parameter logic [COLOR_W-1:0] CLEAR_COLOR   = '0,
   parameter logic [COLOR_W-1:0] OUTSIDE_COLOR = COLOR_W'(COLOR_MAGENTA),
   parameter int unsigned        WQ_DEPTH      = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear_req,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [9:0]         wx,
   input  logic [9:0]         wy,
   input  logic [COLOR_W-1:0] newColor,
   input  logic [9:0]         rx,
   input  logic [9:0]         ry,
   output logic [COLOR_W-1:0] colorCode,
   output logic               busy
);

   localparam int unsigned X_W      = $clog2(CANVAS_W);
   localparam int unsigned Y_W      = $clog2(CANVAS_H);
   localparam int unsigned NPIX     = CANVAS_W * CANVAS_H;
   localparam int unsigned ENTRY_W  = ADDR_W + COLOR_W;
   localparam int unsigned CNT_W    = $clog2(WQ_DEPTH + 1);
   localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(NPIX - 1);

   ram_state_t         state_q, state_d;
   logic [ADDR_W-1:0]  sweep_q, sweep_d;
   logic               wr_ready_q;
   logic               rd_pend_q;
   logic               off_q;
   logic [COLOR_W-1:0] color_q;

   logic [ADDR_W-1:0]  wr_addr;
   logic [ADDR_W-1:0]  disp_addr;
   logic               wr_in_canvas;
   logic               rd_off;

   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] fifo_wr_data;
   logic [ENTRY_W-1:0] fifo_rd_data;
   logic [CNT_W-1:0]   fifo_count;
   logic [CNT_W-1:0]   fifo_count_next;
   logic [ADDR_W-1:0]  fifo_addr;
   logic [COLOR_W-1:0] fifo_color;

   logic [ADDR_W-1:0]  ram_addr;
   logic [RAM_DW-1:0]  ram_din;
   logic               ram_we;
   logic [RAM_DW-1:0]  ram_dout;
   logic               unused_ram;

   // ---------------------------------------------------------------- address / bounds
   assign wr_addr      = pixel_addr(wx, wy, X_W, Y_W);
   assign disp_addr    = pixel_addr(rx, ry, X_W, Y_W);
   assign wr_in_canvas = (32'(wx) < CANVAS_W) && (32'(wy) < CANVAS_H);
   assign rd_off       = (32'(rx) >= CANVAS_W) || (32'(ry) >= CANVAS_H);

   // ---------------------------------------------------------------- slot FSM
   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      if (clear_req) begin
         state_d = RAM_CLEAR;
         sweep_d = '0;
      end else begin
         unique case (state_q)
            RAM_CLEAR: begin
               if (sweep_q == LAST_ADR) state_d = RAM_READ;
               else                     sweep_d = sweep_q + 1'b1;
            end
            RAM_READ:  state_d = RAM_WRITE;
            RAM_WRITE: state_d = RAM_READ;
            default:   begin
               state_d = RAM_CLEAR;
               sweep_d = '0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- write FIFO
   // Off-canvas writes are accepted (handshake completes) but never queued. A clear
   // request flushes the queue and swallows any push offered alongside it.
   assign fifo_push    = wr_valid && wr_ready_q && wr_in_canvas && !clear_req;
   assign fifo_pop     = (state_q == RAM_WRITE) && !fifo_empty && !clear_req;
   assign fifo_wr_data = {wr_addr, newColor};
   assign fifo_addr    = fifo_rd_data[ENTRY_W-1 -: ADDR_W];
   assign fifo_color   = fifo_rd_data[COLOR_W-1:0];

   pixel_write_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (WQ_DEPTH)
   ) u_write_fifo (
      .clk        (clk),
      .reset      (reset),
      .flush      (clear_req),
      .push       (fifo_push),
      .push_data  (fifo_wr_data),
      .pop        (fifo_pop),
      .pop_data   (fifo_rd_data),
      .empty      (fifo_empty),
      .count      (fifo_count),
      .count_next (fifo_count_next)
   );

   // ---------------------------------------------------------------- RAM port mux
   always_comb begin
      ram_addr = disp_addr;
      ram_din  = RAM_DW'(CLEAR_COLOR);
      ram_we   = 1'b0;
      unique case (state_q)
         RAM_CLEAR: begin
            ram_addr = sweep_q;
            ram_we   = 1'b1;
         end
         RAM_WRITE: begin
            if (fifo_pop) begin
               ram_addr = fifo_addr;
               ram_din  = RAM_DW'(fifo_color);
               ram_we   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   pixel_spram u_spram (
      .clk      (clk),
      .addr     (ram_addr),
      .din      (ram_din),
      .maskwe   (4'b1111),
      .we       (ram_we),
      .cs       (1'b1),
      .stdby    (1'b0),
      .sleep    (1'b0),
      .pwroff_n (1'b1),
      .dout     (ram_dout)
   );

   // Only the low COLOR_W bits of a RAM word carry a colour.
   assign unused_ram = ^{ram_dout, fifo_count};

   // ---------------------------------------------------------------- state and output regs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= RAM_CLEAR;
         sweep_q    <= '0;
         wr_ready_q <= 1'b0;
         rd_pend_q  <= 1'b0;
         off_q      <= 1'b0;
         color_q    <= OUTSIDE_COLOR;
      end else begin
         state_q    <= state_d;
         sweep_q    <= sweep_d;
         // Built from next-state occupancy so a push this cycle can never overfill.
         wr_ready_q <= (state_d != RAM_CLEAR) && (32'(fifo_count_next) < WQ_DEPTH);
         rd_pend_q  <= (state_q == RAM_READ);
         if (state_q == RAM_READ) off_q <= rd_off;
         // Forcing OUTSIDE during the sweep keeps stale pre-clear data from reappearing
         // in the two cycles before the first post-sweep read lands.
         if (state_q == RAM_CLEAR) begin
            color_q <= OUTSIDE_COLOR;
         end else if (rd_pend_q) begin
            color_q <= off_q ? OUTSIDE_COLOR : ram_dout[COLOR_W-1:0];
         end
      end
   end

   assign busy      = (state_q == RAM_CLEAR);
   assign wr_ready  = wr_ready_q;
   assign colorCode = busy ? OUTSIDE_COLOR : color_q;

endmodule
